// File: rtl/alu_mc_gated_pkg.sv
// Shared ALU definitions: operation encoding, FSM state type, flag bundle.
// No logic; imported by the top, the interface users and the bench.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
    } flags_t;

endpackage

// File: rtl/alu_mc_gated_if.sv
// Request/response bundle between an ALU client (master) and the ALU (slave).
// Request side is valid/ready; response side is valid/ready.
interface alu_mc_gated_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       alu_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero_flag;
    logic             carry_flag;
    logic             ovf_flag;

    modport master (
        output in_valid, a, b, alu_op, out_ready,
        input  in_ready, out_valid, result, zero_flag, carry_flag, ovf_flag
    );

    modport slave (
        input  in_valid, a, b, alu_op, out_ready,
        output in_ready, out_valid, result, zero_flag, carry_flag, ovf_flag
    );
endinterface

// File: rtl/alu_mc_gated_cg_ctrl.sv
// Clock-gate enable for the downstream datapath: high while busy or requested,
// then held for IDLE_HOLD cycles after going idle. No backpressure.
module alu_cg_ctrl #(
    parameter int IDLE_HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic busy_i,
    input  logic in_valid_i,
    output logic cg_en_o
);

    logic [3:0] idle_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= 4'd0;
        end else if (busy_i || in_valid_i) begin
            idle_cnt_q <= 4'(IDLE_HOLD);
        end else if (idle_cnt_q != 4'd0) begin
            idle_cnt_q <= idle_cnt_q - 4'd1;
        end
    end

    assign cg_en_o = busy_i || in_valid_i || (idle_cnt_q != 4'd0);

endmodule

// File: rtl/alu_mc_gated.sv
// Multi-cycle ALU: 1-cycle bitwise/arith/shift ops, WIDTH-cycle shift-add multiply.
// Result held in HOLD until out_ready; a new request is taken in the same cycle it drains.
module alu_mc_gated
    import alu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int IDLE_HOLD = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_mc_gated_if.slave  bus,
    output logic           cg_en
);

    localparam int SW = $clog2(WIDTH);

    state_e           state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    flags_t           flags_q;

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [SW-1:0]    iter_q;

    logic             accept;
    logic [SW-1:0]    shamt;
    logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    logic [WIDTH:0]   psum;
    logic [WIDTH-1:0] mul_hi_d, mul_lo_d;
    logic             mul_last;

    assign bus.in_ready   = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.out_ready);
    assign accept         = bus.in_valid && bus.in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.zero_flag  = flags_q.zero;
    assign bus.carry_flag = flags_q.carry;
    assign bus.ovf_flag   = flags_q.ovf;

    assign shamt = bus.b[SW-1:0];

    // Shifts are done one bit wider so the last bit shifted out lands in the extra bit.
    always_comb begin
        add_w   = {1'b0, bus.a} + {1'b0, bus.b};
        sub_w   = {1'b0, bus.a} - {1'b0, bus.b};
        shl_w   = {1'b0, bus.a} << shamt;
        shr_w   = {bus.a, 1'b0} >> shamt;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.alu_op)
            OP_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_w[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];
                alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_w[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND: alu_res = bus.a & bus.b;
            OP_OR:  alu_res = bus.a | bus.b;
            OP_XOR: alu_res = bus.a ^ bus.b;
            OP_SHL: begin
                alu_res = shl_w[WIDTH-1:0];
                alu_c   = shl_w[WIDTH];
            end
            OP_SHR: begin
                alu_res = shr_w[WIDTH:1];
                alu_c   = shr_w[0];
            end
            default: ;
        endcase
    end

    // Right-shifting shift-add: {hi,lo} starts as {0,b}, lo drains multiplier bits.
    assign psum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_hi_d = psum[WIDTH:1];
    assign mul_lo_d = {psum[0], lo_q[WIDTH-1:1]};
    assign mul_last = (iter_q == SW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            mcand_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            iter_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        if (bus.alu_op == OP_MUL) begin
                            mcand_q     <= bus.a;
                            hi_q        <= '0;
                            lo_q        <= bus.b;
                            iter_q      <= '0;
                            state_q     <= ST_MUL_RUN;
                            out_valid_q <= 1'b0;
                        end else begin
                            result_q    <= alu_res;
                            flags_q     <= '{zero: (alu_res == '0), carry: alu_c, ovf: alu_v};
                            state_q     <= ST_HOLD;
                            out_valid_q <= 1'b1;
                        end
                    end else if ((state_q == ST_HOLD) && bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_MUL_RUN: begin
                    hi_q   <= mul_hi_d;
                    lo_q   <= mul_lo_d;
                    iter_q <= iter_q + 1'b1;
                    if (mul_last) begin
                        result_q    <= mul_lo_d;
                        flags_q     <= '{zero: (mul_lo_d == '0), carry: (|mul_hi_d), ovf: (|mul_hi_d)};
                        state_q     <= ST_HOLD;
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    alu_cg_ctrl #(
        .IDLE_HOLD(IDLE_HOLD)
    ) u_cg_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .busy_i    (state_q != ST_IDLE),
        .in_valid_i(bus.in_valid),
        .cg_en_o   (cg_en)
    );

endmodule

// File: tb/tb_alu_mc_gated.sv
// Self-checking bench for alu_mc_gated (WIDTH=16, IDLE_HOLD=4): directed cases
// plus random ops against an arithmetic reference model.
module tb_alu_mc_gated;
    import alu_pkg::*;

    localparam int W    = 16;
    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic cg_en;

    always #5 clk = ~clk;

    alu_mc_gated_if #(.WIDTH(W)) bus ();

    alu_mc_gated #(
        .WIDTH    (W),
        .IDLE_HOLD(HOLD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .cg_en(cg_en)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [15:0] res;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation definitions.
    function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t            e;
        int              ua, ub, sa, sb, amt, r;
        longint unsigned p;
        e   = '0;
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        amt = ub % 16;
        case (op)
            3'd0: begin
                r     = ua + ub;
                e.res = 16'(r);
                e.c   = (r > 65535);
                e.v   = ((sa + sb) > 32767) || ((sa + sb) < -32768);
            end
            3'd1: begin
                r     = ua - ub;
                e.res = 16'(r);
                e.c   = (ua < ub);
                e.v   = ((sa - sb) > 32767) || ((sa - sb) < -32768);
            end
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            3'd4: e.res = a ^ b;
            3'd5: begin
                e.res = 16'(ua << amt);
                e.c   = (amt != 0) && (((ua >> (16 - amt)) & 1) != 0);
            end
            3'd6: begin
                e.res = 16'(ua >> amt);
                e.c   = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0);
            end
            default: begin
                p     = longint'(ua) * longint'(ub);
                e.res = 16'(p);
                e.c   = ((p >> 16) != 0);
                e.v   = e.c;
            end
        endcase
        e.z = (e.res == 16'd0);
        return e;
    endfunction

    // Issues one op, waits for the result, checks latency/result/flags, then
    // optionally stalls the consumer for `stall` cycles before releasing it.
    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int stall, output logic [15:0] res_o, output logic c_o);
        exp_t e;
        int   lat;
        int   exp_lat;
        bit   seen;
        e       = model(op, a, b);
        exp_lat = (op == OP_MUL) ? W + 1 : 1;
        @(negedge clk);
        for (int i = 0; i < 40 && !bus.in_ready; i++) @(negedge clk);
        check("in_ready_before_issue", 32'(bus.in_ready), 32'd1);
        bus.out_ready = (stall == 0);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.alu_op    = op;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        bus.alu_op   = 3'($urandom);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) seen = 1'b1;
            else if (op == OP_MUL) check("mul_in_ready_low", 32'(bus.in_ready), 32'd0);
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("result", 32'(bus.result), 32'(e.res));
        check("carry", 32'(bus.carry_flag), 32'(e.c));
        check("ovf", 32'(bus.ovf_flag), 32'(e.v));
        check("zero", 32'(bus.zero_flag), 32'(e.z));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_result", 32'(bus.result), 32'(e.res));
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        res_o         = bus.result;
        c_o           = bus.carry_flag;
        bus.out_ready = 1'b1;
    endtask

    // Call at the negedge before the edge that consumes the last result.
    task automatic check_cg_drop();
        for (int i = 0; i < HOLD; i++) begin
            @(negedge clk);
            check("cg_en_held", 32'(cg_en), 32'd1);
        end
        @(negedge clk);
        check("cg_en_dropped", 32'(cg_en), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=still_running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r;
        logic        c;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.alu_op    = '0;
        bus.out_ready = 1'b1;

        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_flags", 32'({bus.zero_flag, bus.carry_flag, bus.ovf_flag}), 32'd0);
        check("rst_cg_en", 32'(cg_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        run_op(OP_ADD, 16'd65000, 16'd1000, 0, r, c);
        check("add_65000_1000", 32'(r), 32'd464);
        check("add_carry", 32'(c), 32'd1);
        run_op(OP_SUB, 16'd500, 16'd500, 0, r, c);
        check("sub_equal", 32'(r), 32'd0);
        run_op(OP_SUB, 16'd300, 16'd1000, 0, r, c);
        check("sub_borrow_res", 32'(r), 32'd64836);
        check("sub_borrow_c", 32'(c), 32'd1);
        run_op(OP_MUL, 16'd100, 16'd200, 0, r, c);
        check("mul_100_200", 32'(r), 32'd20000);
        check("mul_100_200_c", 32'(c), 32'd0);
        run_op(OP_MUL, 16'd300, 16'd300, 0, r, c);
        check("mul_300_300", 32'(r), 32'd24464);
        check("mul_300_300_c", 32'(c), 32'd1);
        run_op(OP_ADD, 16'h7FFF, 16'h0001, 0, r, c);
        run_op(OP_SUB, 16'h8000, 16'h0001, 0, r, c);
        run_op(OP_SHL, 16'h8001, 16'h0000, 0, r, c);
        run_op(OP_SHL, 16'h0001, 16'hFFF3, 0, r, c);
        check("shl_upper_b_ignored", 32'(r), 32'h8);
        run_op(OP_SHR, 16'h8001, 16'h0001, 0, r, c);
        run_op(OP_SHR, 16'hFFFF, 16'h000F, 0, r, c);
        run_op(OP_MUL, 16'hFFFF, 16'hFFFF, 0, r, c);
        run_op(OP_MUL, 16'h0000, 16'h1234, 0, r, c);

        // Stalled consumer, then back-to-back accepts while draining.
        run_op(OP_ADD, 16'd1, 16'd2, 5, r, c);
        check("stalled_add", 32'(r), 32'd3);
        bus.in_valid = 1'b1;
        bus.a        = 16'hFFFF;
        bus.b        = 16'hAAAA;
        bus.alu_op   = OP_XOR;
        #1;
        check("drain_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.a      = 16'h0001;
        bus.b      = 16'h0004;
        bus.alu_op = OP_SHL;
        @(negedge clk);
        check("b2b_xor_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_xor_result", 32'(bus.result), 32'h5555);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_shl_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_shl_result", 32'(bus.result), 32'h0010);
        check("b2b_shl_carry", 32'(bus.carry_flag), 32'd0);
        check_cg_drop();

        for (int k = 0; k < 40; k++) begin
            run_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, r, c);
        end

        // Reset in the middle of a multiply discards it.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 16'd1234;
        bus.b        = 16'd5678;
        bus.alu_op   = OP_MUL;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("mid_mul_busy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_result", 32'(bus.result), 32'd0);
        check("async_rst_flags", 32'({bus.zero_flag, bus.carry_flag, bus.ovf_flag}), 32'd0);
        check("async_rst_cg_en", 32'(cg_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            check("no_valid_after_rst", 32'(bus.out_valid), 32'd0);
        end
        check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);
        check("cg_en_idle_after_rst", 32'(cg_en), 32'd0);

        run_op(OP_ADD, 16'd10, 16'd20, 0, r, c);
        check("add_after_rst", 32'(r), 32'd30);
        check_cg_drop();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
